fwd_hazard_unit: RTL

- Parametrised next-generation forwarding and hazard unit for the semiMIPS 5-stage pipeline.
- Generalises operand forwarding to NUM_SRC source operands with a third forwarding level: a registered WB-history entry covering regfile read-before-write.
- Adds load-use stall detection, a multi-cycle mul/div busy scoreboard, corrected store-data forwarding, and a saturating stall-cycle counter.
- Sits beside the ID/EX and EX/MEM pipeline registers; drives ALU operand muxes, the store-data mux, PC/IF-ID enables and the ID/EX bubble.

---
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the semiMIPS 5-stage pipeline.
// Selects ALU operand sources (EX/MEM, MEM/WB, or a one-cycle WB history
// entry), forwards store data, and detects load-use and mul/div hazards.
// It also tracks mul/div occupancy and keeps a saturating count of stall cycles.
module fwd_hazard_unit #(
    parameter int REGADDR_W  = 5,
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 2,
    parameter int MULDIV_LAT = 4,
    parameter int STALLCNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC*REGADDR_W-1:0]   idex_src,
    input  logic [NUM_SRC*REGADDR_W-1:0]   ifid_src,
    input  logic [NUM_SRC-1:0]             ifid_src_used,
    input  logic [REGADDR_W-1:0]           idex_dst,
    input  logic                           idex_memrd,
    input  logic                           exmemregwr,
    input  logic [REGADDR_W-1:0]           exmemregmuxout,
    input  logic [REGADDR_W-1:0]           exmemrt,
    input  logic                           exmemmemwr,
    input  logic                           memwbregwr,
    input  logic [REGADDR_W-1:0]           memwbregmuxout,
    input  logic [DATA_W-1:0]              memwb_data,
    input  logic                           md_start,
    input  logic                           ifid_mdread,
    input  logic                           ifid_mdstart,
    output logic [2*NUM_SRC-1:0]           aluforward,
    output logic [DATA_W-1:0]              hist_data,
    output logic                           memdata,
    output logic                           stall,
    output logic                           bubble,
    output logic                           md_busy,
    output logic                           md_err,
    output logic [STALLCNT_W-1:0]          stall_cnt
);

    localparam int MDW = $clog2(MULDIV_LAT + 1);

    logic                 hist_valid;
    logic [REGADDR_W-1:0] hist_addr;
    logic [MDW-1:0]       md_cnt;
    logic                 ld_haz;
    logic                 md_haz;
    logic [REGADDR_W-1:0] fwd_src;
    logic [REGADDR_W-1:0] ld_src;

    // Per-source operand select; youngest matching producer wins, r0 never forwarded
    always_comb begin
        aluforward = '0;
        fwd_src    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fwd_src = idex_src[i*REGADDR_W +: REGADDR_W];
            if (fwd_src == '0)
                aluforward[2*i +: 2] = 2'b00;
            else if (exmemregwr && exmemregmuxout == fwd_src)
                aluforward[2*i +: 2] = 2'b10;
            else if (memwbregwr && memwbregmuxout == fwd_src)
                aluforward[2*i +: 2] = 2'b01;
            else if (hist_valid && hist_addr == fwd_src)
                aluforward[2*i +: 2] = 2'b11;
            else
                aluforward[2*i +: 2] = 2'b00;
        end
    end

    // Store data comes from MEM/WB when it is writing the store's rt
    always_comb begin
        memdata = exmemmemwr && (exmemrt != '0) && memwbregwr
                  && (memwbregmuxout == exmemrt);
    end

    // Load-use: an IF/ID operand that is actually read depends on the load in ID/EX
    always_comb begin
        ld_haz = 1'b0;
        ld_src = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ld_src = ifid_src[i*REGADDR_W +: REGADDR_W];
            if (ifid_src_used[i] && ld_src == idex_dst)
                ld_haz = 1'b1;
        end
        ld_haz = ld_haz && idex_memrd && (idex_dst != '0);
    end

    // Mul/div hazard and combined stall/bubble
    always_comb begin
        md_busy = (md_cnt != '0);
        md_haz  = md_busy && (ifid_mdread || ifid_mdstart);
        stall   = ld_haz || md_haz;
        bubble  = ld_haz || md_haz;
    end

    // One-cycle WB history entry covering regfile read-before-write; ignores stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid <= 1'b0;
            hist_addr  <= '0;
            hist_data  <= '0;
        end else begin
            hist_valid <= memwbregwr && (memwbregmuxout != '0);
            hist_addr  <= memwbregmuxout;
            hist_data  <= memwb_data;
        end
    end

    // Mul/div occupancy counter with sticky overlap error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
            md_err <= 1'b0;
        end else begin
            if (md_start) begin
                md_cnt <= MDW'(MULDIV_LAT);
                if (md_busy)
                    md_err <= 1'b1;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - 1'b1;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
